// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit unsigned adder, one bit per clock LSB first, built from two
// half_adder1 stages plus an OR, framed by a start/busy/done handshake.

module half_adder1 (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// state | meaning
// IDLE  | waiting for start_in; outputs s/c hold the last result
// RUN   | one operand bit pair added per cycle, LSB first
// DONE  | single-cycle done pulse; s/c valid
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_nx;
    logic [CNT_W-1:0] cnt;
    logic             carry_r;
    logic             load, step, finish;
    logic             ha1_s, ha1_c, ha2_s, ha2_c, carry_nx;

    half_adder1 u_ha1 (.a(a_sr[0]), .b(b_sr[0]), .s(ha1_s), .c(ha1_c));
    half_adder1 u_ha2 (.a(ha1_s),   .b(carry_r), .s(ha2_s), .c(ha2_c));

    assign carry_nx = ha1_c | ha2_c;

    always_comb begin
        s_nx = s_sr >> 1;
        s_nx[WIDTH-1] = ha2_s;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nx;
    end

    // DONE accepts a new start so a held start_in yields one result every WIDTH+1 cycles.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start_in) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            s       <= '0;
            c       <= 1'b0;
        end else begin
            if (load) begin
                a_sr    <= a_in;
                b_sr    <= b_in;
                s_sr    <= '0;
                carry_r <= 1'b0;
                cnt     <= '0;
            end else if (step) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                s_sr    <= s_nx;
                carry_r <= carry_nx;
                cnt     <= cnt + 1'b1;
            end
            if (finish) begin
                s <= s_nx;
                c <= carry_nx;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed self-checking bench for serial_adder_seq at WIDTH=8 and WIDTH=1.

module tb_serial_adder_seq;
    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       start_in, start1;
    logic [7:0] a_in, b_in;
    logic [0:0] a1, b1;
    logic       busy, done, c;
    logic [7:0] s;
    logic       busy1, done1, c1;
    logic [0:0] s1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    serial_adder_seq #(.WIDTH(8)) u_dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .s(s), .c(c)
    );

    serial_adder_seq #(.WIDTH(1)) u_dut1 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start1),
        .a_in(a1), .b_in(b1), .busy(busy1), .done(done1), .s(s1), .c(c1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Pulsed start; operands are scrambled after the accept edge to prove capture.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_s, input logic exp_c);
        a_in = a; b_in = b; start_in = 1'b1;
        tick();
        start_in = 1'b0; a_in = ~a; b_in = 8'h5A;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("busy_run", 32'(busy), 32'd1);
            chk("no_done_run", 32'(done), 32'd0);
        end
        tick();
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_low_done", 32'(busy), 32'd0);
        chk("sum", 32'(s), 32'(exp_s));
        chk("carry", 32'(c), 32'(exp_c));
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("sum_hold", 32'(s), 32'(exp_s));
    endtask

    logic [7:0] bb_a [3] = '{8'h12, 8'h80, 8'h0F};
    logic [7:0] bb_b [3] = '{8'h34, 8'h80, 8'hF0};
    logic [7:0] bb_s [3] = '{8'h46, 8'h00, 8'hFF};
    logic       bb_c [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        int pulses;
        rst_n_in = 1'b0; start_in = 1'b0; a_in = '0; b_in = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        tick(); tick();
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_c", 32'(c), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_outputs", {22'd0, s, c, busy, done}, 32'd0);
        end

        run_op(8'h03, 8'h05, 8'h08, 1'b0);
        run_op(8'hFF, 8'h01, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 8'hFE, 1'b1);
        run_op(8'h00, 8'h00, 8'h00, 1'b0);

        // Second request at edge 3 must be dropped.
        a_in = 8'h10; b_in = 8'h20; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick(); tick();
        a_in = 8'h7F; b_in = 8'h7F; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int i = 4; i < 8; i++) tick();
        tick();
        chk("busy_start_done", 32'(done), 32'd1);
        chk("busy_start_sum", 32'(s), 32'h30);
        chk("busy_start_carry", 32'(c), 32'd0);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("no_extra_done", 32'(pulses), 32'd0);

        // Reset at edge 4 aborts.
        a_in = 8'hAA; b_in = 8'h55; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick(); tick(); tick();
        rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_s", 32'(s), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        run_op(8'h01, 8'h01, 8'h02, 1'b0);

        // Back-to-back with start held: accept immediately after each done.
        start_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_in = bb_a[k]; b_in = bb_b[k];
            tick();
            chk("b2b_busy", 32'(busy), 32'd1);
            for (int j = 1; j < 8; j++) begin
                tick();
                chk("b2b_no_early_done", 32'(done), 32'd0);
            end
            tick();
            chk("b2b_done", 32'(done), 32'd1);
            chk("b2b_sum", 32'(s), 32'(bb_s[k]));
            chk("b2b_carry", 32'(c), 32'(bb_c[k]));
        end
        start_in = 1'b0;
        tick();
        chk("b2b_end_done", 32'(done), 32'd0);
        chk("b2b_end_busy", 32'(busy), 32'd0);

        // WIDTH=1 corner.
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        chk("w1_busy", 32'(busy1), 32'd1);
        chk("w1_no_done", 32'(done1), 32'd0);
        tick();
        chk("w1_done", 32'(done1), 32'd1);
        chk("w1_busy_low", 32'(busy1), 32'd0);
        chk("w1_sum", 32'(s1), 32'd0);
        chk("w1_carry", 32'(c1), 32'd1);
        tick();
        chk("w1_done_one_cycle", 32'(done1), 32'd0);
        chk("w1_carry_hold", 32'(c1), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    always @(negedge clk_in) begin
        if (busy && done) begin
            n_cmp++;
            n_err++;
            $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both 1", busy, done);
        end
    end
endmodule
